// File: rtl/benes_ingress_ctrl.sv
// Ingress/egress controller for the 8x8 five-stage Benes network: issues words with skewed
// per-stage switch configs, tracks words in flight and catches results in a credit-protected FIFO.
module benes_ingress_ctrl #(
    parameter int PIPE_LAT   = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int LANES      = 8,
    parameter int W          = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [LANES*W-1:0]   s_data,
    input  logic [5*W-1:0]       s_cfg,
    output logic [LANES*W-1:0]   net_i_port,
    output logic [5*W-1:0]       net_switch_set,
    input  logic [LANES*W-1:0]   net_o_port,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [LANES*W-1:0]   m_data,
    output logic [$clog2(FIFO_DEPTH):0] inflight
);

    localparam int DW     = LANES * W;
    localparam int STAGES = 5;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    logic [DW-1:0]       issData_q;
    logic                issValid_q;
    logic [PIPE_LAT-1:0] valid_q;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [CW-1:0]       count_q, count_d;
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [DW-1:0]       mem_q [0:FIFO_DEPTH-1];
    logic [CW:0]         creditUsed;
    logic                accept;
    logic                capture;
    logic                pop;

    // Credits come only from registered state, so a pop this cycle frees a slot next cycle.
    assign creditUsed = {1'b0, count_q} + {1'b0, inflight_q};
    assign s_ready    = rst_n & (creditUsed < CREDIT_LIMIT);
    assign accept     = s_valid & s_ready;
    assign capture    = valid_q[PIPE_LAT-1];
    assign m_valid    = (count_q != '0);
    assign pop        = m_valid & m_ready;
    assign m_data     = m_valid ? mem_q[rptr_q] : '0;
    assign net_i_port = issData_q;
    assign inflight   = inflight_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issData_q  <= '0;
            issValid_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            issData_q  <= accept ? s_data : '0;
            issValid_q <= accept;
            valid_q    <= {valid_q[PIPE_LAT-2:0], issValid_q};
        end
    end

    // Stage k's config rides a 2k-deep delay line so it lands on the same cycle as its word.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] line_q [0:2*k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= 2*k; j++) line_q[j] <= '0;
            end else begin
                line_q[0] <= accept ? s_cfg[k*W +: W] : '0;
                for (int j = 1; j <= 2*k; j++) line_q[j] <= line_q[j-1];
            end
        end

        assign net_switch_set[k*W +: W] = line_q[2*k];
    end

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        case ({accept, capture})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({capture, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (capture) wptr_d = wptr_q + AW'(1);
        if (pop)     rptr_d = rptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage needs no reset: m_data is gated by m_valid and pointers are cleared.
    always_ff @(posedge clk) begin
        if (capture) mem_q[wptr_q] <= net_o_port;
    end

endmodule

// File: tb/tb_benes_ingress_ctrl.sv
// Randomised bench for benes_ingress_ctrl against a queue/timestamp model of the
// controller, with a 9-cycle lane-reversing stand-in for the Benes network.
module tb_benes_ingress_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [19:0] s_cfg;
    logic [31:0] net_i_port;
    logic [19:0] net_switch_set;
    logic [31:0] net_o_port;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [4:0]  inflight;

    always #5 clk = ~clk;

    benes_ingress_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_cfg          (s_cfg),
        .net_i_port     (net_i_port),
        .net_switch_set (net_switch_set),
        .net_o_port     (net_o_port),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .inflight       (inflight)
    );

    function automatic logic [31:0] laneRev(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = x[4*(7-i) +: 4];
        return r;
    endfunction

    // Network stand-in: fixed 9-cycle latency, lanes reversed so the result differs from the input.
    logic [31:0] netPipe [0:8];
    always @(posedge clk) begin
        netPipe[0] <= net_i_port;
        for (int i = 1; i < 9; i++) netPipe[i] <= netPipe[i-1];
    end
    assign net_o_port = laneRev(netPipe[8]);

    typedef struct {
        logic [31:0] data;
        int          capEdge;
    } flight_t;

    flight_t     flightQ[$];
    logic [31:0] fifoQ[$];
    logic [31:0] dataHist[int];
    logic [19:0] cfgHist[int];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int accObserved = 0;
    int occObserved = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic checkPostEdge();
        logic [31:0] expData;
        logic [19:0] expSet;
        logic [19:0] c;
        int          e;
        expData = dataHist.exists(cyc) ? dataHist[cyc] : 32'h0;
        expSet  = '0;
        for (int k = 0; k < 5; k++) begin
            e = cyc - 2*k;
            if (cfgHist.exists(e)) begin
                c = cfgHist[e];
                expSet[4*k +: 4] = c[4*k +: 4];
            end
        end
        checkOutput("net_i_port", net_i_port, expData);
        checkOutput("net_switch_set", 32'(net_switch_set), 32'(expSet));
        checkOutput("inflight", 32'(inflight), 32'(flightQ.size()));
        checkOutput("m_valid", 32'(m_valid), 32'(fifoQ.size() > 0));
        if (fifoQ.size() > 0) checkOutput("m_data", m_data, fifoQ[0]);
    endtask

    // One clock cycle: drive inputs, check ready, advance the model across the edge, check outputs.
    task automatic applyStimulus(input logic sv, input logic [31:0] sd, input logic [19:0] sc,
                                 input logic mr);
        logic expReady;
        logic acc;
        logic pop;
        s_valid = sv;
        s_data  = sd;
        s_cfg   = sc;
        m_ready = mr;
        #1;
        expReady = rst_n && ((fifoQ.size() + flightQ.size()) < 16);
        checkOutput("s_ready", 32'(s_ready), 32'(expReady));
        if (s_valid && s_ready) begin
            accObserved++;
            occObserved++;
        end
        if (m_valid && m_ready) occObserved--;
        checkOutput("credit_bound", 32'(occObserved <= 16), 32'd1);
        acc = sv && expReady;
        pop = mr && (fifoQ.size() > 0);
        @(posedge clk);
        cyc++;
        if (pop) void'(fifoQ.pop_front());
        while (flightQ.size() > 0 && flightQ[0].capEdge == cyc) begin
            fifoQ.push_back(laneRev(flightQ[0].data));
            void'(flightQ.pop_front());
        end
        if (acc) begin
            flightQ.push_back('{data: sd, capEdge: cyc + 10});
            dataHist[cyc] = sd;
            cfgHist[cyc]  = sc;
        end
        #1;
        checkPostEdge();
    endtask

    task automatic doReset(input int n);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_data", m_data, 32'd0);
        checkOutput("rst_net_i", net_i_port, 32'd0);
        checkOutput("rst_sw_set", 32'(net_switch_set), 32'd0);
        checkOutput("rst_inflight", 32'(inflight), 32'd0);
        flightQ.delete();
        fifoQ.delete();
        dataHist.delete();
        cfgHist.delete();
        occObserved = 0;
        repeat (n) @(posedge clk);
        cyc += n;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input logic mr);
        repeat (n) applyStimulus(1'b0, 32'h0, 20'h0, mr);
    endtask

    initial begin
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_cfg   = '0;
        m_ready = 1'b0;
        #2;
        doReset(3);

        applyStimulus(1'b1, 32'h7654_3210, 20'h0, 1'b1);
        idle(14, 1'b1);

        applyStimulus(1'b1, $urandom, 20'hFEDCB, 1'b1);
        idle(14, 1'b1);

        for (int i = 0; i < 20; i++) applyStimulus(1'b1, $urandom, 20'($urandom), 1'b1);
        idle(15, 1'b1);

        accObserved = 0;
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, $urandom, 20'($urandom), 1'b0);
        checkOutput("bp_accepts", 32'(accObserved), 32'd16);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, $urandom, 20'($urandom), 1'b1);
        idle(30, 1'b1);

        for (int i = 0; i < 200; i++)
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 20'($urandom),
                          1'($urandom_range(0, 3) != 0));
        idle(30, 1'b1);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom, 20'($urandom), 1'b0);
        doReset(2);
        idle(15, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
